// File: rtl/ame_num_expand.sv
// ame_num_expand: signed operand times +/-2^exp, 3-stage pipeline with init/done pulses.
// Define AME_NUM_EXPAND_SAT_EN to saturate the result on overflow instead of wrapping.
//
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   comp_init_i  one-cycle start pulse; samples data, exp, neg
//   comp_data_i  signed two's-complement operand
//   comp_exp_i   unsigned left-shift amount
//   comp_neg_i   1 = negate the result
//   comp_done_o  one-cycle pulse, result valid (held until next done)
//   comp_data_o  signed result
//   comp_ovf_o   result exceeded the signed range
module ame_num_expand #(
    parameter int COMP_DATA_BITS = 64,
    parameter int COMP_EXP_BITS  = $clog2(COMP_DATA_BITS)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      comp_init_i,
    input  logic [COMP_DATA_BITS-1:0] comp_data_i,
    input  logic [COMP_EXP_BITS-1:0]  comp_exp_i,
    input  logic                      comp_neg_i,
    output logic                      comp_done_o,
    output logic [COMP_DATA_BITS-1:0] comp_data_o,
    output logic                      comp_ovf_o
);

    localparam int W = COMP_DATA_BITS;
    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

    // stage 1 state
    logic                     v1;
    logic [W-1:0]             mag1;
    logic                     rsign1;
    logic [COMP_EXP_BITS-1:0] exp1;

    // stage 2 state
    logic                     v2;
    logic [W-1:0]             shifted2;
    logic                     lost2;
    logic                     zero2;
    logic                     rsign2;

    logic [W-1:0] mag_c;
    logic [W-1:0] shifted_c;
    logic [W-1:0] top_mask_c;
    logic         lost_c;
    logic [W-1:0] limit_c;
    logic         ovf_c;
    logic [W-1:0] wrap_c;
    logic [W-1:0] res_c;

    // |x| of the most negative value wraps to itself, which is the correct unsigned magnitude
    always_comb begin
        mag_c = comp_data_i[W-1] ? -comp_data_i : comp_data_i;
    end

    // top_mask_c selects the exp bits that fall off the top during the shift
    always_comb begin
        shifted_c  = mag1 << exp1;
        top_mask_c = ~(ALL_ONE >> exp1);
        lost_c     = |(mag1 & top_mask_c);
    end

    always_comb begin
        limit_c = rsign2 ? NEG_MIN : POS_MAX;
        ovf_c   = !zero2 && (lost2 || (shifted2 > limit_c));
        wrap_c  = rsign2 ? -shifted2 : shifted2;
`ifdef AME_NUM_EXPAND_SAT_EN
        res_c   = ovf_c ? limit_c : wrap_c;
`else
        res_c   = wrap_c;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1     <= 1'b0;
            mag1   <= '0;
            rsign1 <= 1'b0;
            exp1   <= '0;
        end else begin
            v1 <= comp_init_i;
            if (comp_init_i) begin
                mag1   <= mag_c;
                rsign1 <= comp_data_i[W-1] ^ comp_neg_i;
                exp1   <= comp_exp_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v2       <= 1'b0;
            shifted2 <= '0;
            lost2    <= 1'b0;
            zero2    <= 1'b0;
            rsign2   <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                shifted2 <= shifted_c;
                lost2    <= lost_c;
                zero2    <= (mag1 == '0);
                rsign2   <= rsign1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            comp_done_o <= 1'b0;
            comp_data_o <= '0;
            comp_ovf_o  <= 1'b0;
        end else begin
            comp_done_o <= v2;
            if (v2) begin
                comp_data_o <= res_c;
                comp_ovf_o  <= ovf_c;
            end
        end
    end

endmodule

// File: doc/ame_num_expand.md
Name: ame_num_expand

Overview:
- Inverse of the AME log2 approximation path: scales a signed 64-bit operand by a power of two taken from a 6-bit exponent, with optional sign inversion.
- Computes comp_data_o = (comp_neg_i ? -1 : +1) * comp_data_i * 2^comp_exp_i.
- Sits after the approximation encoder, rebuilding full-width values from exponent form for the AME cost and scaling datapath.
- 3-stage pipeline with the same init/done pulse handshake as the rest of the AME blocks.

Parameters:
- COMP_DATA_BITS, 64, operand/result width; must be a power of two, 8..64.
- COMP_EXP_BITS, $clog2(COMP_DATA_BITS), exponent width; derived, do not override.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  asynchronous active-low reset
- comp_init_i  input  1  one-cycle pulse; samples comp_data_i, comp_exp_i, comp_neg_i
- comp_data_i  input  COMP_DATA_BITS  signed two's-complement operand
- comp_exp_i  input  COMP_EXP_BITS  unsigned left-shift amount, 0..COMP_DATA_BITS-1
- comp_neg_i  input  1  1 = negate result
- comp_done_o  output  1  one-cycle pulse; comp_data_o/comp_ovf_o valid this cycle and held until next done
- comp_data_o  output  COMP_DATA_BITS  signed result, registered
- comp_ovf_o  output  1  result exceeded signed range; registered, qualified by comp_done_o

Behaviour:
- Reset: async on rst_n_i low. All pipeline valids, comp_done_o, comp_data_o and comp_ovf_o are 0. Any in-flight operation is discarded with no done pulse.
- Latency: init in cycle N -> done in cycle N+3. Fully pipelined; init accepted every cycle; results emerge in order, one per init; no stall/backpressure.
- Stage 1 (on init):
  - mag = |comp_data_i| as unsigned COMP_DATA_BITS; |-2^63| = 2^63 is representable unsigned.
  - rsign = comp_data_i[MSB] XOR comp_neg_i.
  - Latch exp.
- Stage 2:
  - shifted = mag << exp, truncated to COMP_DATA_BITS.
  - lost = OR of the top exp bits of mag (bits shifted out).
  - zero = (mag == 0).
- Stage 3:
  - limit = rsign ? 2^(W-1) : 2^(W-1)-1, where W = COMP_DATA_BITS.
  - ovf = !zero & (lost | shifted > limit).
  - Result = rsign ? -shifted : shifted, mod 2^W.
  - Zero operand yields 0 and ovf = 0 for any exp/neg; rsign is ignored.
- comp_data_o and comp_ovf_o update only in the done cycle and hold otherwise.
- exp = 0: result = ±operand. The only overflow case is comp_data_i = -2^(W-1) with comp_neg_i = 1 (magnitude 2^(W-1) > positive limit).
- comp_init_i during reset deassertion cycle: ignored if rst_n_i is low at the clock edge.

Optional Feature:
- Macro: AME_NUM_EXPAND_SAT_EN.
- Defined:
  - On ovf, comp_data_o saturates to 0x7FFF_FFFF_FFFF_FFFF when rsign = 0, or 0x8000_0000_0000_0000 when rsign = 1 (shown for W = 64).
  - comp_ovf_o reports the overflow.
- Undefined:
  - comp_data_o is the wrapped value (operand * ±2^exp mod 2^W).
  - comp_ovf_o is still computed and reported identically.
  - No saturation logic is synthesized.

Test Plan:
- Reset mid-flight: init with data=5, exp=2; assert rst_n_i in the next cycle -> no done pulse; outputs 0 after release; the next init completes normally in 3 cycles.
- Basic: data=3, exp=4, neg=0 -> done at N+3, data_o=48, ovf=0. Same operands with neg=1 -> data_o=-48 (0xFFFF_FFFF_FFFF_FFD0), ovf=0.
- Back-to-back: inits on 4 consecutive cycles with (1,0), (1,63), (-1,63), (0,63), all neg=0 -> 4 consecutive done pulses:
  - 1, ovf=0.
  - 2^63 overflow: ovf=1; data_o = 0x7FFF_FFFF_FFFF_FFFF with SAT_EN, 0x8000_0000_0000_0000 without.
  - -2^63 = 0x8000_0000_0000_0000, ovf=0.
  - 0, ovf=0.
- Edge negate: data = 0x8000_0000_0000_0000, exp=0, neg=1 -> ovf=1; data_o = 0x7FFF_FFFF_FFFF_FFFF with SAT_EN, 0x8000_0000_0000_0000 without.
- Lost bits: data = 0x0100_0000_0000_0001, exp=8 -> ovf=1; data_o = 0x7FFF_FFFF_FFFF_FFFF with SAT_EN, 0x0000_0000_0000_0100 without. Data = 0x0040_0000_0000_0000, exp=8 -> data_o = 0x4000_0000_0000_0000, ovf=0.
- Random: 10k random operands and exponents vs. a reference model, both macro settings -> exact match; done count equals init count.
